// File: rtl/otter_fetch_unit_if.sv
// rtl/otter_fetch_unit_if.sv - fetch unit bus bundle: PC port, instruction memory, decode handshake
interface otter_fetch_unit_if;
    logic        FETCH_EN;
    logic [31:0] PC_COUNT;
    logic        PC_WRITE;
    logic [31:0] PC_DIN;
    logic        MEM_RDEN;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_DOUT;
    logic        REDIRECT;
    logic [31:0] REDIRECT_ADDR;
    logic [31:0] IR;
    logic [31:0] IR_PC;
    logic        IR_VALID;
    logic        IR_READY;

    // Fetch unit side
    modport master (
        input  FETCH_EN, PC_COUNT, MEM_DOUT, REDIRECT, REDIRECT_ADDR, IR_READY,
        output PC_WRITE, PC_DIN, MEM_RDEN, MEM_ADDR, IR, IR_PC, IR_VALID
    );

    // Core / memory side
    modport slave (
        output FETCH_EN, PC_COUNT, MEM_DOUT, REDIRECT, REDIRECT_ADDR, IR_READY,
        input  PC_WRITE, PC_DIN, MEM_RDEN, MEM_ADDR, IR, IR_PC, IR_VALID
    );
endinterface

// File: rtl/otter_fetch_unit.sv
// rtl/otter_fetch_unit.sv - OTTER instruction fetch front end with credit-based instruction queue
module otter_fetch_unit #(
    parameter int DEPTH = 3
) (
    input  logic              clk,
    input  logic              FETCH_RST,
    otter_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   q_ir [DEPTH];
    logic [31:0]   q_pc [DEPTH];
    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic          valid;
    logic          unused_addr_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Queued entries plus the outstanding read; a same-cycle pop earns no credit.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign valid     = (count != '0);
    // A response landing in a redirect cycle belongs to the abandoned path.
    assign push      = inflight & ~bus.REDIRECT;
    assign pop       = valid & bus.IR_READY;

    // Fetch state register
    always_ff @(posedge clk or posedge FETCH_RST) begin
        if (FETCH_RST) state <= IDLE;
        else           state <= state_next;
    end

    // Next-state: fetching follows FETCH_EN
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.FETCH_EN)  state_next = RUN;
            RUN:     if (!bus.FETCH_EN) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Issue decision: only in RUN, never during a redirect, only with a free slot
    always_comb begin
        issue = 1'b0;
        if (state == RUN && !bus.REDIRECT && occupancy < DEPTH_OCC)
            issue = 1'b1;
    end

    assign bus.MEM_RDEN = issue;
    assign bus.MEM_ADDR = bus.PC_COUNT;
    assign bus.PC_WRITE = bus.REDIRECT | issue;
    assign bus.PC_DIN   = bus.REDIRECT ? {bus.REDIRECT_ADDR[31:2], 2'b00}
                                       : bus.PC_COUNT + 32'd4;
    assign bus.IR       = q_ir[head];
    assign bus.IR_PC    = q_pc[head];
    assign bus.IR_VALID = valid;

    assign unused_addr_bits = ^bus.REDIRECT_ADDR[1:0];

    // Outstanding read tracking; redirect suppresses issue so it also clears this
    always_ff @(posedge clk or posedge FETCH_RST) begin
        if (FETCH_RST) begin
            inflight    <= 1'b0;
            inflight_pc <= 32'd0;
        end else begin
            inflight    <= issue;
            inflight_pc <= bus.PC_COUNT;
        end
    end

    // Instruction queue: FIFO of {instruction, pc}, flushed on redirect
    always_ff @(posedge clk or posedge FETCH_RST) begin
        if (FETCH_RST) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_ir[i] <= 32'd0;
                q_pc[i] <= 32'd0;
            end
        end else if (bus.REDIRECT) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) begin
                q_ir[tail] <= bus.MEM_DOUT;
                q_pc[tail] <= inflight_pc;
                tail       <= ptr_inc(tail);
            end
            if (pop)
                head <= ptr_inc(head);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (FETCH_RST) !(push && occupancy > DEPTH_OCC - 1 && count == DEPTH_OCC[CW-1:0])
    );

endmodule

// File: tb/tb_otter_fetch_unit.sv
// tb/tb_otter_fetch_unit.sv - self-checking bench for otter_fetch_unit
module tb_otter_fetch_unit;
    typedef struct {
        logic        en;
        logic        rdy;
        logic        redir;
        logic [31:0] raddr;
        logic        v;
        logic [31:0] pc;
        logic        rden;
        logic        wr;
        logic [31:0] din;
        logic [31:0] pcc;
    } vec_t;

    logic        clk = 1'b0;
    logic        fetch_rst;
    logic [31:0] pc_reg;
    logic [31:0] mem_dout;
    int          checks   = 0;
    int          failures = 0;
    vec_t        vecs[$];

    otter_fetch_unit_if bus();

    otter_fetch_unit #(.DEPTH(3)) dut (
        .clk       (clk),
        .FETCH_RST (fetch_rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Program counter register shares the fetch reset
    always @(posedge clk or posedge fetch_rst) begin
        if (fetch_rst)         pc_reg <= 32'd0;
        else if (bus.PC_WRITE) pc_reg <= bus.PC_DIN;
    end
    assign bus.PC_COUNT = pc_reg;

    // Synchronous instruction memory: word = inverted address
    always @(posedge clk) begin
        if (bus.MEM_RDEN) mem_dout <= ~bus.MEM_ADDR;
    end
    assign bus.MEM_DOUT = mem_dout;

    function automatic vec_t mk(input logic en, input logic rdy, input logic redir,
                                input logic [31:0] raddr, input logic v, input logic [31:0] pc,
                                input logic rden, input logic wr, input logic [31:0] din,
                                input logic [31:0] pcc);
        vec_t r;
        r.en = en; r.rdy = rdy; r.redir = redir; r.raddr = raddr;
        r.v = v; r.pc = pc; r.rden = rden; r.wr = wr; r.din = din; r.pcc = pcc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            bus.FETCH_EN      = vecs[i].en;
            bus.IR_READY      = vecs[i].rdy;
            bus.REDIRECT      = vecs[i].redir;
            bus.REDIRECT_ADDR = vecs[i].raddr;
            #1;
            chk_bit($sformatf("v%0d_valid", i), bus.IR_VALID, vecs[i].v);
            chk_bit($sformatf("v%0d_rden", i), bus.MEM_RDEN, vecs[i].rden);
            chk_bit($sformatf("v%0d_pcwrite", i), bus.PC_WRITE, vecs[i].wr);
            chk($sformatf("v%0d_pccount", i), bus.PC_COUNT, vecs[i].pcc);
            if (vecs[i].v) begin
                chk($sformatf("v%0d_ir_pc", i), bus.IR_PC, vecs[i].pc);
                chk($sformatf("v%0d_ir", i), bus.IR, ~vecs[i].pc);
            end
            if (vecs[i].rden)
                chk($sformatf("v%0d_mem_addr", i), bus.MEM_ADDR, vecs[i].pcc);
            if (vecs[i].wr)
                chk($sformatf("v%0d_pc_din", i), bus.PC_DIN, vecs[i].din);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        fetch_rst         = 1'b1;
        bus.FETCH_EN      = 1'b0;
        bus.IR_READY      = 1'b0;
        bus.REDIRECT      = 1'b0;
        bus.REDIRECT_ADDR = 32'd0;
        @(posedge clk);
        @(negedge clk);
        #2;
        fetch_rst = 1'b0;
    endtask

    logic [31:0] got_pc [16];
    logic [31:0] got_ir [16];
    int          got_n;
    int          first_j;

    initial begin
        fetch_rst         = 1'b1;
        bus.FETCH_EN      = 1'b0;
        bus.IR_READY      = 1'b0;
        bus.REDIRECT      = 1'b0;
        bus.REDIRECT_ADDR = 32'd0;

        // Part 1: stream from reset with IR_READY held high
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,     0, 0, 0,      0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,     1, 1, 32'h4,  0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,     1, 1, 32'h8,  32'h4));
        vecs.push_back(mk(1, 1, 0, 0, 1, 32'h0, 1, 1, 32'hC,  32'h8));
        vecs.push_back(mk(1, 1, 0, 0, 1, 32'h4, 1, 1, 32'h10, 32'hC));
        vecs.push_back(mk(1, 1, 0, 0, 1, 32'h8, 1, 1, 32'h14, 32'h10));
        // Part 2: backpressure from reset, release, redirect with a read in flight
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,     0, 0, 0,      0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,     1, 1, 32'h4,  0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,     1, 1, 32'h8,  32'h4));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0, 1, 1, 32'hC,  32'h8));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0, 0, 0, 0, 32'hC));
        vecs.push_back(mk(1, 1, 0, 0,      1, 32'h0,   0, 0, 0,       32'hC));
        vecs.push_back(mk(1, 0, 0, 0,      1, 32'h4,   1, 1, 32'h10,  32'hC));
        vecs.push_back(mk(1, 0, 1, 32'h100, 1, 32'h4,  0, 1, 32'h100, 32'h10));
        vecs.push_back(mk(1, 1, 0, 0,      0, 0,       1, 1, 32'h104, 32'h100));
        vecs.push_back(mk(1, 1, 0, 0,      0, 0,       1, 1, 32'h108, 32'h104));
        vecs.push_back(mk(1, 1, 0, 0,      1, 32'h100, 1, 1, 32'h10C, 32'h108));
        vecs.push_back(mk(1, 1, 0, 0,      1, 32'h104, 1, 1, 32'h110, 32'h10C));
        vecs.push_back(mk(1, 1, 0, 0,      1, 32'h108, 1, 1, 32'h114, 32'h110));

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_bit("rst_ir_valid", bus.IR_VALID, 1'b0);
        chk_bit("rst_mem_rden", bus.MEM_RDEN, 1'b0);
        chk_bit("rst_pc_write", bus.PC_WRITE, 1'b0);
        chk("rst_ir", bus.IR, 32'd0);
        chk("rst_ir_pc", bus.IR_PC, 32'd0);
        #1;
        fetch_rst = 1'b0;

        run_vectors(0, 5);

        // Asynchronous reset mid-stream, between clock edges
        #1;
        fetch_rst    = 1'b1;
        bus.FETCH_EN = 1'b0;
        #1;
        chk_bit("midrst_ir_valid", bus.IR_VALID, 1'b0);
        chk_bit("midrst_mem_rden", bus.MEM_RDEN, 1'b0);
        chk_bit("midrst_pc_write", bus.PC_WRITE, 1'b0);
        chk("midrst_pc_count", bus.PC_COUNT, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2;
        fetch_rst = 1'b0;

        run_vectors(6, vecs.size() - 1);

        // Redirect while idle: PC is written with the aligned target, no fetch
        do_reset();
        @(negedge clk);
        bus.REDIRECT      = 1'b1;
        bus.REDIRECT_ADDR = 32'h203;
        #1;
        chk_bit("idle_redir_pc_write", bus.PC_WRITE, 1'b1);
        chk("idle_redir_pc_din", bus.PC_DIN, 32'h200);
        chk_bit("idle_redir_rden", bus.MEM_RDEN, 1'b0);
        @(negedge clk);
        bus.REDIRECT = 1'b0;
        #1;
        chk_bit("idle_after_pc_write", bus.PC_WRITE, 1'b0);
        chk_bit("idle_after_rden", bus.MEM_RDEN, 1'b0);
        chk("idle_after_pc_count", bus.PC_COUNT, 32'h200);
        chk_bit("idle_after_valid", bus.IR_VALID, 1'b0);

        // PC wraparound through 0xFFFFFFFC
        for (int k = 0; k < 16; k++) begin
            got_pc[k] = 32'hDEADBEEF;
            got_ir[k] = 32'hDEADBEEF;
        end
        got_n   = 0;
        first_j = -1;
        @(negedge clk);
        bus.FETCH_EN      = 1'b1;
        bus.IR_READY      = 1'b1;
        bus.REDIRECT      = 1'b1;
        bus.REDIRECT_ADDR = 32'hFFFF_FFF8;
        #1;
        chk("wrap_redir_din", bus.PC_DIN, 32'hFFFF_FFF8);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            bus.REDIRECT = 1'b0;
            #1;
            if (bus.IR_VALID && got_n < 16) begin
                if (first_j < 0) first_j = j;
                got_pc[got_n] = bus.IR_PC;
                got_ir[got_n] = bus.IR;
                got_n++;
            end
        end
        chk("wrap_first_valid_cycle", 32'(first_j), 32'd3);
        chk("wrap_pc0", got_pc[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", got_pc[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", got_pc[2], 32'h0000_0000);
        chk("wrap_ir2", got_ir[2], 32'hFFFF_FFFF);
        chk("wrap_count", 32'(got_n), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
